// File: rtl/sodor5_itype_golden.sv
// sodor5_itype_golden: golden decoder/executor for the RV32I OP-IMM stream.
// Three stages: D (decode, register read), X (ALU), WB (record + regfile commit).
// One record per accepted instruction. Illegal words give a record with wb_illegal=1.
// Optional macro SODOR5_GOLDEN_FWD_EN: forward the X result into the D operand
// instead of stalling D for one cycle on an X->D dependency.
module sodor5_itype_golden #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              init_we,
    input  logic [REG_AW-1:0] init_addr,
    input  logic [XLEN-1:0]   init_data,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_illegal,
    output logic [31:0]       retired_count
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [XLEN-1:0]   regs [NUM_REGS];

    logic              d_valid;
    logic [31:0]       d_instr;
    logic [6:0]        d_opcode;
    logic [REG_AW-1:0] d_rd;
    logic [2:0]        d_funct3;
    logic [REG_AW-1:0] d_rs1;
    logic [11:0]       d_imm;
    logic              d_legal;
    logic [XLEN-1:0]   rf_rd;
    logic [XLEN-1:0]   d_op_a;

    logic              x_valid;
    logic              x_legal;
    logic [REG_AW-1:0] x_rd;
    logic [2:0]        x_funct3;
    logic [11:0]       x_imm;
    logic [XLEN-1:0]   x_a;
    logic [XLEN-1:0]   x_imm_sx;
    logic [XLEN-1:0]   x_result;
    logic              x_writes;

    logic              hazard;
    logic              stall;

    assign d_opcode = d_instr[6:0];
    assign d_rd     = d_instr[7 +: REG_AW];
    assign d_funct3 = d_instr[14:12];
    assign d_rs1    = d_instr[15 +: REG_AW];
    assign d_imm    = d_instr[31:20];

    // x0 always reads as zero; the array entry behind it is never written
    assign rf_rd = (d_rs1 == '0) ? '0 : regs[d_rs1];

    assign x_writes = x_valid && x_legal && (x_rd != '0);
    assign hazard   = d_valid && x_writes && (x_rd == d_rs1);

`ifdef SODOR5_GOLDEN_FWD_EN
    assign stall  = 1'b0;
    assign d_op_a = hazard ? x_result : rf_rd;
`else
    // D waits one cycle so the X result lands in the regfile before the re-read
    assign stall  = hazard;
    assign d_op_a = rf_rd;
`endif

    assign in_ready = !stall;

    // OP-IMM legality, including the funct7-like upper immediate bits of the shifts
    always_comb begin
        d_legal = (d_opcode == OPC_OP_IMM);
        if (d_funct3 == 3'd1)
            d_legal = d_legal && (d_imm[11:5] == 7'b0000000);
        if (d_funct3 == 3'd5)
            d_legal = d_legal && ((d_imm[11:5] == 7'b0000000) || (d_imm[11:5] == 7'b0100000));
    end

    assign x_imm_sx = {{(XLEN-12){x_imm[11]}}, x_imm};

    // X-stage ALU
    always_comb begin
        x_result = '0;
        case (x_funct3)
            3'd0: x_result = x_a + x_imm_sx;
            3'd1: x_result = x_a << x_imm[4:0];
            3'd2: x_result = {{(XLEN-1){1'b0}}, ($signed(x_a) < $signed(x_imm_sx))};
            3'd3: x_result = {{(XLEN-1){1'b0}}, (x_a < x_imm_sx)};
            3'd4: x_result = x_a ^ x_imm_sx;
            3'd5: x_result = x_imm[10] ? XLEN'($signed(x_a) >>> x_imm[4:0]) : (x_a >> x_imm[4:0]);
            3'd6: x_result = x_a | x_imm_sx;
            3'd7: x_result = x_a & x_imm_sx;
            default: x_result = '0;
        endcase
    end

    // D stage: load on handshake, hold while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_valid <= 1'b0;
            d_instr <= '0;
        end else if (!stall) begin
            d_valid <= in_valid;
            d_instr <= in_instr;
        end
    end

    // X stage: advances every cycle, bubble when D is empty or stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_valid  <= 1'b0;
            x_legal  <= 1'b0;
            x_rd     <= '0;
            x_funct3 <= '0;
            x_imm    <= '0;
            x_a      <= '0;
        end else begin
            x_valid  <= d_valid && !stall;
            x_legal  <= d_legal;
            x_rd     <= d_rd;
            x_funct3 <= d_funct3;
            x_imm    <= d_imm;
            x_a      <= d_op_a;
        end
    end

    // WB record registers and retired counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            wb_illegal    <= 1'b0;
            retired_count <= '0;
        end else begin
            wb_valid   <= x_valid;
            wb_rd      <= x_valid ? x_rd : '0;
            wb_data    <= x_writes ? x_result : '0;
            wb_illegal <= x_valid && !x_legal;
            if (x_valid && x_legal)
                retired_count <= retired_count + 32'd1;
        end
    end

    // Shadow regfile (not reset); the pipeline write is last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (init_we && (init_addr != '0))
            regs[init_addr] <= init_data;
        if (x_writes)
            regs[x_rd] <= x_result;
    end

endmodule
